// File: rtl/game_pkg.sv
// Shared types and widths for the game round controller and its helpers.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned TIME_W  = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises a raw asynchronous button level and emits a registered
// one-cycle pulse on its rising edge.
module btn_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], level};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Timed game round sequencer: countdown, answer acceptance with lockout,
// saturating score and game-over flag.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned MAX_SCORE    = 99,
  parameter int unsigned LOCKOUT_CYC  = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               answer,
  output logic               game_over,
  output logic               running,
  output logic [SCORE_W-1:0] score,
  output logic               score_inc,
  output logic [TIME_W-1:0]  time_left
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LOCK_W = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);
  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_SECONDS);
  localparam logic [LOCK_W-1:0]  LOCK_INIT = LOCK_W'(LOCKOUT_CYC);

  // CLK_HZ is informational; a zero value almost certainly means a bad override.
  if (TICK_DIV < 2 || CLK_HZ == 0) begin : g_bad_params
    $error("game_round_ctrl: TICK_DIV must be >= 2 and CLK_HZ nonzero");
  end

  game_state_t       state;
  logic [TICK_W-1:0] tick_cnt;
  logic [LOCK_W-1:0] lockout;
  logic              start_rise;
  logic              answer_rise;

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .level (start),
    .rise  (start_rise)
  );

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_answer_sync (
    .clk   (clk),
    .rst   (rst),
    .level (answer),
    .rise  (answer_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      score     <= '0;
      time_left <= '0;
      tick_cnt  <= '0;
      lockout   <= '0;
      score_inc <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      score_inc <= 1'b0;
      case (state)
        // A coincident answer edge is deliberately not counted on the start cycle.
        IDLE, OVER: begin
          if (start_rise) begin
            state     <= RUN;
            running   <= 1'b1;
            game_over <= 1'b0;
            score     <= '0;
            time_left <= TIME_INIT;
            tick_cnt  <= '0;
            lockout   <= '0;
          end
        end
        RUN: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (time_left == TIME_W'(1)) begin
              time_left <= '0;
              state     <= OVER;
              running   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              time_left <= time_left - TIME_W'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end

          // Lockout reloads even at saturation so a held-off player stays held off.
          if (answer_rise && lockout == '0) begin
            lockout <= LOCK_INIT;
            if (score < SCORE_MAX) begin
              score     <= score + SCORE_W'(1);
              score_inc <= 1'b1;
            end
          end else if (lockout != '0) begin
            lockout <= lockout - LOCK_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl; a second instance with a longer round
// exercises score saturation.
module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, answer = 1'b0;
  logic       start_s = 1'b0, answer_s = 1'b0;
  logic       game_over, running, score_inc;
  logic [6:0] score;
  logic [7:0] time_left;
  logic       game_over_s, running_s, score_inc_s;
  logic [6:0] score_s;
  logic [7:0] time_left_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .CLK_HZ(100), .TICK_DIV(4), .GAME_SECONDS(3), .MAX_SCORE(5),
    .LOCKOUT_CYC(2), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .answer(answer),
    .game_over(game_over), .running(running), .score(score),
    .score_inc(score_inc), .time_left(time_left)
  );

  game_round_ctrl #(
    .CLK_HZ(100), .TICK_DIV(4), .GAME_SECONDS(10), .MAX_SCORE(5),
    .LOCKOUT_CYC(2), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .answer(answer_s),
    .game_over(game_over_s), .running(running_s), .score(score_s),
    .score_inc(score_inc_s), .time_left(time_left_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pin edge in cycle i reaches the score on the 4th clock after it.
  task automatic drive_answer(input bit sat, input logic [63:0] pat, input int n,
                              output int incs);
    incs = 0;
    for (int i = 0; i < n; i++) begin
      if (sat) answer_s = pat[i];
      else     answer   = pat[i];
      step();
      if (sat ? score_inc_s : score_inc) incs++;
    end
    answer   = 1'b0;
    answer_s = 1'b0;
  endtask

  // Leaves time at the first sample where RUN is visible.
  task automatic start_round(input bit sat);
    if (sat) start_s = 1'b1;
    else     start   = 1'b1;
    step();
    start   = 1'b0;
    start_s = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_over();
    int k;
    k = 0;
    while (!game_over && k < 60) begin
      step();
      k++;
    end
    vectors++;
    if (game_over !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_over: game_over=%b after %0d cycles, want 1", game_over, k);
    end
  endtask

  task automatic test_reset();
    int incs;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    vectors += 5;
    if (game_over !== 1'b0) begin miscompares++; $display("FAIL rst_game_over: got %b want 0", game_over); end
    if (running !== 1'b0) begin miscompares++; $display("FAIL rst_running: got %b want 0", running); end
    if (score !== 7'd0) begin miscompares++; $display("FAIL rst_score: got %0d want 0", score); end
    if (score_inc !== 1'b0) begin miscompares++; $display("FAIL rst_score_inc: got %b want 0", score_inc); end
    if (time_left !== 8'd0) begin miscompares++; $display("FAIL rst_time_left: got %0d want 0", time_left); end
    drive_answer(1'b0, 64'h5, 10, incs);
    vectors += 3;
    if (incs != 0) begin miscompares++; $display("FAIL idle_answer_incs: got %0d want 0", incs); end
    if (score !== 7'd0) begin miscompares++; $display("FAIL idle_answer_score: got %0d want 0", score); end
    if (running !== 1'b0) begin miscompares++; $display("FAIL idle_running: got %b want 0", running); end
  endtask

  task automatic test_countdown();
    logic [7:0] exp_t;
    logic       exp_over;
    start_round(1'b0);
    vectors += 3;
    if (running !== 1'b1) begin miscompares++; $display("FAIL cd_running: got %b want 1", running); end
    if (time_left !== 8'd3) begin miscompares++; $display("FAIL cd_time_init: got %0d want 3", time_left); end
    if (game_over !== 1'b0) begin miscompares++; $display("FAIL cd_over_init: got %b want 0", game_over); end
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_t    = (c < 4) ? 8'd3 : (c < 8) ? 8'd2 : (c < 12) ? 8'd1 : 8'd0;
      exp_over = (c == 12);
      vectors += 3;
      if (time_left !== exp_t) begin miscompares++; $display("FAIL cd_time c=%0d: got %0d want %0d", c, time_left, exp_t); end
      if (game_over !== exp_over) begin miscompares++; $display("FAIL cd_over c=%0d: got %b want %b", c, game_over, exp_over); end
      if (running !== !exp_over) begin miscompares++; $display("FAIL cd_running c=%0d: got %b want %b", c, running, !exp_over); end
    end
  endtask

  task automatic test_lockout();
    int incs;
    start_round(1'b0);
    vectors += 3;
    if (running !== 1'b1) begin miscompares++; $display("FAIL lo_restart_running: got %b want 1", running); end
    if (score !== 7'd0) begin miscompares++; $display("FAIL lo_restart_score: got %0d want 0", score); end
    if (time_left !== 8'd3) begin miscompares++; $display("FAIL lo_restart_time: got %0d want 3", time_left); end
    drive_answer(1'b0, 64'h5, 8, incs);
    vectors += 2;
    if (incs != 1) begin miscompares++; $display("FAIL lo_gap2_incs: got %0d want 1", incs); end
    if (score !== 7'd1) begin miscompares++; $display("FAIL lo_gap2_score: got %0d want 1", score); end
    wait_over();
    start_round(1'b0);
    drive_answer(1'b0, 64'h9, 9, incs);
    vectors += 2;
    if (incs != 2) begin miscompares++; $display("FAIL lo_gap3_incs: got %0d want 2", incs); end
    if (score !== 7'd2) begin miscompares++; $display("FAIL lo_gap3_score: got %0d want 2", score); end
    wait_over();
  endtask

  task automatic test_saturation();
    int incs;
    start_round(1'b1);
    drive_answer(1'b1, 64'h1111_1111, 34, incs);
    vectors += 3;
    if (incs != 5) begin miscompares++; $display("FAIL sat_incs: got %0d want 5", incs); end
    if (score_s !== 7'd5) begin miscompares++; $display("FAIL sat_score: got %0d want 5", score_s); end
    if (running_s !== 1'b1) begin miscompares++; $display("FAIL sat_running: got %b want 1", running_s); end
  endtask

  task automatic test_final_tick();
    int incs;
    start_round(1'b0);
    for (int i = 0; i < 12; i++) begin
      answer = (i == 8);
      step();
      if (i == 10) begin
        vectors += 2;
        if (game_over !== 1'b0) begin miscompares++; $display("FAIL ft_early_over: got %b want 0", game_over); end
        if (score !== 7'd0) begin miscompares++; $display("FAIL ft_early_score: got %0d want 0", score); end
      end
    end
    answer = 1'b0;
    vectors += 5;
    if (score !== 7'd1) begin miscompares++; $display("FAIL ft_score: got %0d want 1", score); end
    if (score_inc !== 1'b1) begin miscompares++; $display("FAIL ft_score_inc: got %b want 1", score_inc); end
    if (game_over !== 1'b1) begin miscompares++; $display("FAIL ft_over: got %b want 1", game_over); end
    if (running !== 1'b0) begin miscompares++; $display("FAIL ft_running: got %b want 0", running); end
    if (time_left !== 8'd0) begin miscompares++; $display("FAIL ft_time: got %0d want 0", time_left); end
    drive_answer(1'b0, 64'h1, 7, incs);
    vectors += 2;
    if (incs != 0) begin miscompares++; $display("FAIL over_answer_incs: got %0d want 0", incs); end
    if (score !== 7'd1) begin miscompares++; $display("FAIL over_answer_score: got %0d want 1", score); end
  endtask

  task automatic test_start_with_answer();
    start  = 1'b1;
    answer = 1'b1;
    step();
    start  = 1'b0;
    answer = 1'b0;
    repeat (3) step();
    vectors += 3;
    if (running !== 1'b1) begin miscompares++; $display("FAIL swa_running: got %b want 1", running); end
    if (score !== 7'd0) begin miscompares++; $display("FAIL swa_score: got %0d want 0", score); end
    if (score_inc !== 1'b0) begin miscompares++; $display("FAIL swa_score_inc: got %b want 0", score_inc); end
    step();
    vectors += 2;
    if (score !== 7'd0) begin miscompares++; $display("FAIL swa_score_next: got %0d want 0", score); end
    if (score_inc !== 1'b0) begin miscompares++; $display("FAIL swa_inc_next: got %b want 0", score_inc); end
    wait_over();
  endtask

  task automatic test_reset_mid_run();
    int incs;
    start_round(1'b0);
    drive_answer(1'b0, 64'h9, 8, incs);
    vectors += 2;
    if (score !== 7'd2) begin miscompares++; $display("FAIL mr_pre_score: got %0d want 2", score); end
    if (running !== 1'b1) begin miscompares++; $display("FAIL mr_pre_running: got %b want 1", running); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors += 4;
    if (running !== 1'b0) begin miscompares++; $display("FAIL mr_running: got %b want 0", running); end
    if (game_over !== 1'b0) begin miscompares++; $display("FAIL mr_over: got %b want 0", game_over); end
    if (score !== 7'd0) begin miscompares++; $display("FAIL mr_score: got %0d want 0", score); end
    if (time_left !== 8'd0) begin miscompares++; $display("FAIL mr_time: got %0d want 0", time_left); end
    start_round(1'b0);
    vectors += 3;
    if (running !== 1'b1) begin miscompares++; $display("FAIL mr_new_running: got %b want 1", running); end
    if (time_left !== 8'd3) begin miscompares++; $display("FAIL mr_new_time: got %0d want 3", time_left); end
    if (score !== 7'd0) begin miscompares++; $display("FAIL mr_new_score: got %0d want 0", score); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_lockout();
    test_saturation();
    test_final_tick();
    test_start_with_answer();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
